// File: rtl/wb_sdram_bridge_if.sv
`default_nettype none
// ============================================================================
// wb_sdram_bridge_if : Wishbone slave bus and sdram_controller request bus
// Revision: 1.0
// ============================================================================
interface wb_sdram_bridge_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [22:0] ctrl_addr;
   logic        ctrl_rw;
   logic [31:0] ctrl_wdata;
   logic        ctrl_in_valid;
   logic        ctrl_busy;
   logic [31:0] ctrl_rdata;
   logic        ctrl_out_valid;
   logic        bridge_err;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  ctrl_busy, ctrl_rdata, ctrl_out_valid,
      output wbs_ack_o, wbs_dat_o, ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid,
      output bridge_err
   );

   // Upstream Wishbone master together with the controller it talks to.
   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output ctrl_busy, ctrl_rdata, ctrl_out_valid,
      input  wbs_ack_o, wbs_dat_o, ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_in_valid,
      input  bridge_err
   );
endinterface
`default_nettype wire

// File: rtl/wb_sdram_bridge.sv
`default_nettype none
// ============================================================================
// wb_sdram_bridge : Wishbone-classic slave -> single-word sdram_controller requests
// Optional macro SDRAM_BRIDGE_PREFETCH_EN adds a one-entry next-word read prefetch.
// Revision: 1.0
// ============================================================================
module wb_sdram_bridge #(
   parameter logic [31:0] ADDR_BASE  = 32'h3800_0000,
   parameter logic [31:0] ADDR_MASK  = 32'hFE00_0000,
   parameter int          RD_TIMEOUT = 64
) (
   input  wire logic        clk,
   input  wire logic        rst,
   wb_sdram_bridge_if.slave bus
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   localparam logic [3:0] S_IDLE        = 4'd0;
   localparam logic [3:0] S_RD_REQ      = 4'd1;
   localparam logic [3:0] S_RD_WAIT     = 4'd2;
   localparam logic [3:0] S_WR_REQ      = 4'd3;
   localparam logic [3:0] S_RMW_RD_REQ  = 4'd4;
   localparam logic [3:0] S_RMW_RD_WAIT = 4'd5;
   localparam logic [3:0] S_ACK         = 4'd6;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
   localparam logic [3:0] S_PF_REQ      = 4'd7;
   localparam logic [3:0] S_PF_WAIT     = 4'd8;
`endif

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [22:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic [3:0]       sel_q;
   logic             err_q;

   logic             hit;
   logic             timeout;
   logic [22:0]      word;
   logic [31:0]      merged;

`ifdef SDRAM_BRIDGE_PREFETCH_EN
   logic [22:0]      pf_addr_q;
   logic [31:0]      pf_data_q;
   logic             pf_valid_q;
   logic             pf_arm_q;
   logic             pf_hit;

   assign pf_hit = pf_valid_q && (pf_addr_q == word);
`endif

   assign hit     = bus.wbs_cyc_i && bus.wbs_stb_i &&
                    ((bus.wbs_adr_i & ADDR_MASK) == ADDR_BASE);
   assign word    = bus.wbs_adr_i[24:2];
   assign timeout = (cnt_q == CNT_W'(RD_TIMEOUT - 1));

   // Byte lanes being written come from the master, the rest from the old word.
   always_comb begin
      merged = '0;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = sel_q[i] ? wdata_q[8*i +: 8] : bus.ctrl_rdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               if (!bus.wbs_we_i) begin
                  state_d = S_RD_REQ;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                  if (pf_hit) state_d = S_ACK;
`endif
               end else if (bus.wbs_sel_i == 4'hF) begin
                  state_d = S_WR_REQ;
               end else begin
                  state_d = S_RMW_RD_REQ;
               end
            end
         end
         S_RD_REQ:      if (!bus.ctrl_busy) state_d = S_RD_WAIT;
         S_RD_WAIT:     if (bus.ctrl_out_valid || timeout) state_d = S_ACK;
         S_WR_REQ:      if (!bus.ctrl_busy) state_d = S_ACK;
         S_RMW_RD_REQ:  if (!bus.ctrl_busy) state_d = S_RMW_RD_WAIT;
         S_RMW_RD_WAIT: begin
            if (bus.ctrl_out_valid)  state_d = S_WR_REQ;
            else if (timeout)        state_d = S_ACK;
         end
         S_ACK: begin
`ifdef SDRAM_BRIDGE_PREFETCH_EN
            state_d = pf_arm_q ? S_PF_REQ : S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
`ifdef SDRAM_BRIDGE_PREFETCH_EN
         S_PF_REQ:      if (!bus.ctrl_busy) state_d = S_PF_WAIT;
         S_PF_WAIT:     if (bus.ctrl_out_valid || timeout) state_d = S_IDLE;
`endif
         default:       state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ctrl_in_valid = 1'b0;
      bus.ctrl_rw       = 1'b0;
      bus.wbs_ack_o     = 1'b0;
      case (state_q)
         S_RD_REQ, S_RMW_RD_REQ: bus.ctrl_in_valid = !bus.ctrl_busy;
         S_WR_REQ: begin
            bus.ctrl_in_valid = !bus.ctrl_busy;
            bus.ctrl_rw       = 1'b1;
         end
`ifdef SDRAM_BRIDGE_PREFETCH_EN
         S_PF_REQ:               bus.ctrl_in_valid = !bus.ctrl_busy;
`endif
         S_ACK:                  bus.wbs_ack_o     = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         sel_q      <= '0;
         err_q      <= 1'b0;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
         pf_addr_q  <= '0;
         pf_data_q  <= '0;
         pf_valid_q <= 1'b0;
         pf_arm_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hit) begin
                  addr_q  <= word;
                  wdata_q <= bus.wbs_dat_i;
                  sel_q   <= bus.wbs_sel_i;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                  if (bus.wbs_we_i && (pf_addr_q == word)) pf_valid_q <= 1'b0;
                  if (!bus.wbs_we_i && pf_hit)             rdata_q    <= pf_data_q;
`endif
               end
            end
            S_RD_REQ, S_RMW_RD_REQ: cnt_q <= '0;
            S_RD_WAIT: begin
               if (bus.ctrl_out_valid) begin
                  rdata_q <= bus.ctrl_rdata;
`ifdef SDRAM_BRIDGE_PREFETCH_EN
                  pf_arm_q <= 1'b1;
`endif
               end else if (timeout) begin
                  rdata_q <= 32'hFFFF_FFFF;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RMW_RD_WAIT: begin
               if (bus.ctrl_out_valid) wdata_q <= merged;
               else if (timeout)       err_q   <= 1'b1;
               else                    cnt_q   <= cnt_q + CNT_W'(1);
            end
`ifdef SDRAM_BRIDGE_PREFETCH_EN
            // Entry is invalidated up front so a prefetch timeout leaves it empty.
            S_ACK: begin
               if (pf_arm_q) begin
                  pf_arm_q   <= 1'b0;
                  pf_valid_q <= 1'b0;
                  addr_q     <= addr_q + 23'd1;
               end
            end
            S_PF_REQ: cnt_q <= '0;
            S_PF_WAIT: begin
               if (bus.ctrl_out_valid) begin
                  pf_addr_q  <= addr_q;
                  pf_data_q  <= bus.ctrl_rdata;
                  pf_valid_q <= 1'b1;
               end else if (timeout) begin
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.ctrl_addr  = addr_q;
   assign bus.ctrl_wdata = wdata_q;
   assign bus.wbs_dat_o  = rdata_q;
   assign bus.bridge_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_sdram_bridge.sv
`default_nettype none
// ============================================================================
// tb_wb_sdram_bridge : randomized scoreboard bench with an SDRAM controller stub
// Revision: 1.0
// ============================================================================
module tb_wb_sdram_bridge;
   localparam int RD_TIMEOUT = 64;
   localparam int XFER_LIMIT = 200;

   typedef struct packed {
      logic        is_rd;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_sdram_bridge_if bif ();

   wb_sdram_bridge #(
      .ADDR_BASE  (32'h3800_0000),
      .ADDR_MASK  (32'hFE00_0000),
      .RD_TIMEOUT (RD_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat;
   logic        busy_force, busy_rand, busy_rand_en;
   logic        st_ov;
   logic [31:0] st_rdata;

   assign bif.wbs_cyc_i      = cyc;
   assign bif.wbs_stb_i      = stb;
   assign bif.wbs_we_i       = we;
   assign bif.wbs_sel_i      = sel;
   assign bif.wbs_adr_i      = adr;
   assign bif.wbs_dat_i      = dat;
   assign bif.ctrl_busy      = busy_force | busy_rand;
   assign bif.ctrl_out_valid = st_ov;
   assign bif.ctrl_rdata     = st_rdata;

   int n_checks = 0;
   int n_pass   = 0;
   int n_ack    = 0;
   int n_iv     = 0;

   exp_t        sb_q[$];
   logic [31:0] ref_mem [logic [22:0]];
   logic        ref_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Controller stub: stores writes, answers reads after stub_lat cycles.
   logic [31:0] smem [0:255];
   logic        st_pend;
   int          st_wcnt;
   logic [22:0] st_addr;
   logic [22:0] st_last_addr;
   logic        st_respond;
   int          stub_lat;

   always @(posedge clk) begin
      st_ov <= 1'b0;
      if (rst) begin
         st_pend      <= 1'b0;
         st_last_addr <= '0;
         for (int i = 0; i < 256; i++) smem[i] <= 32'h0;
      end else begin
         if (st_pend) begin
            if (st_wcnt == 0) begin
               st_ov    <= 1'b1;
               st_rdata <= smem[st_addr[7:0]];
               st_pend  <= 1'b0;
            end else begin
               st_wcnt <= st_wcnt - 1;
            end
         end
         if (bif.ctrl_in_valid) begin
            st_last_addr <= bif.ctrl_addr;
            if (bif.ctrl_rw) begin
               smem[bif.ctrl_addr[7:0]] <= bif.ctrl_wdata;
            end else if (st_respond) begin
               st_pend <= 1'b1;
               st_wcnt <= stub_lat - 2;
               st_addr <= bif.ctrl_addr;
            end
         end
      end
   end

   always @(negedge clk) busy_rand <= !rst && busy_rand_en && ($urandom_range(0, 2) == 0);

   always begin : monitor
      exp_t e;
      @(negedge clk);
      #1;
      if (!rst && bif.ctrl_in_valid) begin
         n_iv++;
         chk("iv_while_busy", {31'd0, bif.ctrl_busy}, 32'd0);
      end
      if (bif.wbs_ack_o) begin
         n_ack++;
         chk("ack_has_pending", {31'd0, sb_q.size() > 0}, 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.is_rd) chk("rd_data", bif.wbs_dat_o, e.data);
            chk("err_flag", {31'd0, bif.bridge_err}, {31'd0, e.err});
         end
      end
   end

   function automatic logic [31:0] ref_rd(input logic [22:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endfunction

   task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output int lat, output logic got);
      @(negedge clk);
      adr = a; we = w; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < XFER_LIMIT) begin
         @(posedge clk);
         #1;
         lat++;
         if (bif.wbs_ack_o) got = 1'b1;
      end
      cyc = 1'b0;
      stb = 1'b0;
   endtask

   task automatic do_op(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, output int lat);
      exp_t        e;
      logic        got;
      logic [22:0] wa;
      logic [31:0] cur;
      wa  = a[24:2];
      cur = ref_rd(wa);
      e.is_rd = !w;
      e.data  = cur;
      e.err   = ref_err;
      if (w) begin
         for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
         ref_mem[wa] = cur;
      end
      sb_q.push_back(e);
      wb_xfer(a, w, s, d, lat, got);
      chk("ack_seen", {31'd0, got}, 32'd1);
      if (!got) sb_q.delete(sb_q.size() - 1);
   endtask

   task automatic quiet();
      repeat (12) @(negedge clk);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int   lat, iv0, ack0;
      logic got;
      exp_t e;
      cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
      busy_force = 0; busy_rand_en = 0; st_respond = 1; stub_lat = 2; ref_err = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ack",   {31'd0, bif.wbs_ack_o},     32'd0);
      chk("rst_iv",    {31'd0, bif.ctrl_in_valid}, 32'd0);
      chk("rst_dat",   bif.wbs_dat_o,              32'd0);
      chk("rst_err",   {31'd0, bif.bridge_err},    32'd0);
      chk("rst_caddr", {9'd0, bif.ctrl_addr},      32'd0);
      @(negedge clk);
      rst = 0;

      // Full write then read back
      quiet();
      do_op(32'h3800_0010, 1'b1, 4'hF, 32'hA5A5_1234, lat);
      chk("wr_latency", lat, 32'd2);
      chk("wr_ctrl_addr", {9'd0, st_last_addr}, 32'h0000_0004);
      quiet();
      stub_lat = 3;
      do_op(32'h3800_0010, 1'b0, 4'hF, 32'h0, lat);
      chk("rd_latency", lat, 32'd5);

      // Partial write becomes read + write at the controller
      quiet();
      iv0 = n_iv;
      do_op(32'h3800_0010, 1'b1, 4'b0010, 32'h0000_CD00, lat);
      chk("rmw_pulses", n_iv - iv0, 32'd2);
      quiet();
      do_op(32'h3800_0010, 1'b0, 4'hF, 32'h0, lat);

      // Controller busy holds off the request
      quiet();
      busy_force = 1'b1;
      fork
         do_op(32'h3800_0040, 1'b0, 4'hF, 32'h0, lat);
         begin
            iv0 = n_iv;
            repeat (20) @(negedge clk);
            chk("iv_during_busy", n_iv - iv0, 32'd0);
            busy_force = 1'b0;
            #1;
            chk("iv_on_busy_fall", {31'd0, bif.ctrl_in_valid}, 32'd1);
            @(negedge clk);
            #1;
            chk("iv_single_pulse", {31'd0, bif.ctrl_in_valid}, 32'd0);
         end
      join

      // Read timeout
      quiet();
      st_respond = 1'b0;
      e.is_rd = 1'b1; e.data = 32'hFFFF_FFFF; e.err = 1'b1;
      sb_q.push_back(e);
      wb_xfer(32'h3800_0050, 1'b0, 4'hF, 32'h0, lat, got);
      chk("to_ack_seen", {31'd0, got}, 32'd1);
      if (!got) sb_q.delete(sb_q.size() - 1);
      chk("to_latency", {31'd0, (lat >= RD_TIMEOUT + 1) && (lat <= RD_TIMEOUT + 3)}, 32'd1);
      ref_err = 1'b1;
      st_respond = 1'b1;
      quiet();
      chk("err_sticky", {31'd0, bif.bridge_err}, 32'd1);
      do_op(32'h3800_0010, 1'b0, 4'hF, 32'h0, lat);

      // Address outside the window is ignored
      quiet();
      iv0 = n_iv; ack0 = n_ack;
      wb_xfer(32'h3000_0000, 1'b0, 4'hF, 32'h0, lat, got);
      chk("nohit_ack", {31'd0, got}, 32'd0);
      chk("nohit_iv", n_iv - iv0, 32'd0);
      chk("nohit_ack_cnt", n_ack - ack0, 32'd0);

      // Reset while waiting for read data
      quiet();
      st_respond = 1'b0;
      ack0 = n_ack;
      @(negedge clk);
      adr = 32'h3800_0060; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_ack",   {31'd0, bif.wbs_ack_o},     32'd0);
      chk("mid_rst_iv",    {31'd0, bif.ctrl_in_valid}, 32'd0);
      chk("mid_rst_dat",   bif.wbs_dat_o,              32'd0);
      chk("mid_rst_err",   {31'd0, bif.bridge_err},    32'd0);
      chk("mid_rst_caddr", {9'd0, bif.ctrl_addr},      32'd0);
      chk("mid_rst_wdata", bif.ctrl_wdata,             32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_err = 1'b0;
      ref_mem.delete();
      st_respond = 1'b1;
      quiet();
      chk("mid_rst_no_ack", n_ack - ack0, 32'd0);
      do_op(32'h3800_0010, 1'b0, 4'hF, 32'h0, lat);

`ifdef SDRAM_BRIDGE_PREFETCH_EN
      quiet();
      do_op(32'h3800_0020, 1'b0, 4'hF, 32'h0, lat);
      quiet();
      iv0 = n_iv;
      do_op(32'h3800_0024, 1'b0, 4'hF, 32'h0, lat);
      chk("pf_hit_latency", lat, 32'd1);
      chk("pf_hit_no_iv", n_iv - iv0, 32'd0);
      quiet();
      do_op(32'h39FF_FFFC, 1'b0, 4'hF, 32'h0, lat);
      quiet();
      chk("pf_wrap_addr", {9'd0, st_last_addr}, 32'd0);
      do_op(32'h3800_0000, 1'b0, 4'hF, 32'h0, lat);
      chk("pf_wrap_hit_latency", lat, 32'd1);
      quiet();
      do_op(32'h3800_0004, 1'b1, 4'hF, 32'h1357_9BDF, lat);
      quiet();
      iv0 = n_iv;
      do_op(32'h3800_0004, 1'b0, 4'hF, 32'h0, lat);
      chk("pf_inval_to_ctrl", n_iv - iv0, 32'd1);
`endif

      // Randomized traffic against the reference memory
      busy_rand_en = 1'b1;
      repeat (60) begin
         stub_lat = $urandom_range(2, 6);
         do_op(32'h3800_0000 + ($urandom_range(0, 63) << 2), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom, lat);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      busy_rand_en = 1'b0;
      quiet();
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
